// File: rtl/watch_pkg.sv
// Shared mode encodings, BCD limits and the hour-increment helper for the watch time counter.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
    logic       pm;
  } hour_t;

  // 24h wraps 23->00; 12h wraps 12->01 and toggles pm on 11->12.
  function automatic hour_t hour_inc(input hour_t h, input logic h24);
    hour_t r;
    r = h;
    if (h24) begin
      if (h.tens == 2'(HR24_MAX / 10) && h.ones == 4'(HR24_MAX % 10)) begin
        r.tens = 2'd0;
        r.ones = 4'd0;
      end else if (h.ones == 4'd9) begin
        r.tens = h.tens + 2'd1;
        r.ones = 4'd0;
      end else begin
        r.ones = h.ones + 4'd1;
      end
    end else begin
      if (h.tens == 2'(HR12_MAX / 10) && h.ones == 4'(HR12_MAX % 10)) begin
        r.tens = 2'd0;
        r.ones = 4'd1;
      end else if (h.tens == 2'd1 && h.ones == 4'd1) begin
        r.ones = 4'd2;
        r.pm   = ~h.pm;
      end else if (h.ones == 4'd9) begin
        r.tens = 2'd1;
        r.ones = 4'd0;
      end else begin
        r.ones = h.ones + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with synchronous clear; wrap flags the MAX->00 increment.
module bcd_mod_counter #(
  parameter int MAX    = 59,
  parameter int TENS_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [3:0]        ones,
  output logic [TENS_W-1:0] tens,
  output logic              wrap
);

  localparam logic [3:0]        ONES_MAX = 4'(MAX % 10);
  localparam logic [TENS_W-1:0] TENS_MAX = TENS_W'(MAX / 10);

  logic [3:0]        ones_q, ones_d;
  logic [TENS_W-1:0] tens_q, tens_d;
  logic              at_max_s;

  assign at_max_s = (ones_q == ONES_MAX) && (tens_q == TENS_MAX);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = {TENS_W{1'b0}};
    end else if (inc) begin
      if (at_max_s) begin
        ones_d = 4'd0;
        tens_d = {TENS_W{1'b0}};
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + TENS_W'(1);
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      ones_d = ones_q;
      tens_d = tens_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
      tens_q <= {TENS_W{1'b0}};
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;
  assign wrap = inc & ~clr & at_max_s;

endmodule

// File: rtl/watch_time_counter.sv
// BCD HH:MM:SS time-of-day counter advanced by rising edges of the divider's slow clock,
// with a RUN -> SET_HR -> SET_MIN set-time FSM driven by one-cycle button pulses.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter bit HOUR_24       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       pm,
  output logic [1:0] mode,
  output logic       sec_pulse
);

  localparam int              PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam hour_t           HR_RESET   = HOUR_24 ? {2'd0, 4'd0, 1'b0} : {2'd1, 4'd2, 1'b0};

  mode_e         state_q, state_d;
  logic [1:0]    mode_s;
  logic          tick_q;
  logic [PW-1:0] presc_q, presc_d;
  hour_t         hr_q, hr_d;
  logic          sec_pulse_q;

  logic rise_s, advance_s, set_inc_s, sec_clr_s;
  logic sec_wrap_s, min_wrap_s, min_inc_s, hr_inc_s;

  // A rise only counts when the sampled level goes 0->1; tick_q clears on reset.
  assign rise_s    = tick_in & ~tick_q;
  assign advance_s = rise_s && (state_q == MODE_RUN) && (presc_q == PRESC_LAST);
  assign set_inc_s = btn_inc & ~btn_mode;
  assign sec_clr_s = (state_q == MODE_SET_MIN) && btn_mode;
  assign min_inc_s = ((state_q == MODE_SET_MIN) && set_inc_s) || (advance_s && sec_wrap_s);
  assign hr_inc_s  = ((state_q == MODE_SET_HR) && set_inc_s) || (advance_s && min_wrap_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MODE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = MODE_RUN;
    case (state_q)
      MODE_RUN:     state_d = btn_mode ? MODE_SET_HR  : MODE_RUN;
      MODE_SET_HR:  state_d = btn_mode ? MODE_SET_MIN : MODE_SET_HR;
      MODE_SET_MIN: state_d = btn_mode ? MODE_RUN     : MODE_SET_MIN;
      default:      state_d = MODE_RUN;
    endcase
  end

  always_comb begin
    mode_s = state_q;
  end

  always_comb begin
    presc_d = presc_q;
    if (sec_clr_s) begin
      presc_d = {PW{1'b0}};
    end else if (rise_s && (state_q == MODE_RUN)) begin
      presc_d = advance_s ? {PW{1'b0}} : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  always_comb begin
    hr_d = hr_q;
    if (hr_inc_s) begin
      hr_d = hour_inc(hr_q, HOUR_24);
    end else begin
      hr_d = hr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q      <= 1'b0;
      presc_q     <= {PW{1'b0}};
      hr_q        <= HR_RESET;
      sec_pulse_q <= 1'b0;
    end else begin
      tick_q      <= tick_in;
      presc_q     <= presc_d;
      hr_q        <= hr_d;
      sec_pulse_q <= advance_s;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX), .TENS_W(3)) u_sec (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sec_clr_s),
    .inc  (advance_s),
    .ones (sec_ones),
    .tens (sec_tens),
    .wrap (sec_wrap_s)
  );

  bcd_mod_counter #(.MAX(SEC_MAX), .TENS_W(3)) u_min (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (min_inc_s),
    .ones (min_ones),
    .tens (min_tens),
    .wrap (min_wrap_s)
  );

  assign hr_ones   = hr_q.ones;
  assign hr_tens   = hr_q.tens;
  assign pm        = HOUR_24 ? 1'b0 : hr_q.pm;
  assign mode      = mode_s;
  assign sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench: three instances (24h, 12h, 4 ticks/s) share stimulus; each scenario checks one.
module tb_watch_time_counter;

  typedef enum int {OP_RST, OP_TICK, OP_MODE, OP_INC, OP_BOTH} op_e;
  typedef struct {
    op_e         op;
    int          n;
    logic [23:0] exp_time;
    logic [1:0]  exp_mode;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  int checks = 0;
  int errors = 0;
  int a_pulses = 0;

  logic [3:0] a_so, a_mo, a_ho, b_so, b_mo, b_ho, c_so, c_mo, c_ho;
  logic [2:0] a_st, a_mt, b_st, b_mt, c_st, c_mt;
  logic [1:0] a_ht, b_ht, c_ht, a_mode, b_mode, c_mode;
  logic       a_pm, b_pm, c_pm, a_sp, b_sp, c_sp;
  logic [23:0] a_time, b_time, c_time;

  assign a_time = {2'b00, a_ht, a_ho, 1'b0, a_mt, a_mo, 1'b0, a_st, a_so};
  assign b_time = {2'b00, b_ht, b_ho, 1'b0, b_mt, b_mo, 1'b0, b_st, b_so};
  assign c_time = {2'b00, c_ht, c_ho, 1'b0, c_mt, c_mo, 1'b0, c_st, c_so};

  always #5 clk = ~clk;

  always @(posedge clk) if (a_sp) a_pulses <= a_pulses + 1;

  watch_time_counter #(.TICKS_PER_SEC(1), .HOUR_24(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .hr_ones(a_ho), .hr_tens(a_ht), .pm(a_pm), .mode(a_mode), .sec_pulse(a_sp));

  watch_time_counter #(.TICKS_PER_SEC(1), .HOUR_24(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .hr_ones(b_ho), .hr_tens(b_ht), .pm(b_pm), .mode(b_mode), .sec_pulse(b_sp));

  watch_time_counter #(.TICKS_PER_SEC(4), .HOUR_24(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_ones(c_so), .sec_tens(c_st), .min_ones(c_mo), .min_tens(c_mt),
    .hr_ones(c_ho), .hr_tens(c_ht), .pm(c_pm), .mode(c_mode), .sec_pulse(c_sp));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_hold();
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = ~tick;
      @(negedge clk);
    end
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_rise();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_op(input op_e op, input int n);
    for (int i = 0; i < n; i++) begin
      case (op)
        OP_RST:  begin reset_hold(); reset_release(); end
        OP_TICK: do_rise();
        OP_MODE: press(1'b1, 1'b0);
        OP_INC:  press(1'b0, 1'b1);
        OP_BOTH: press(1'b1, 1'b1);
        default: ;
      endcase
    end
  endtask

  vec_t vecs [20];
  int   p0;

  initial begin
    vecs[0]  = '{OP_RST,  1,  24'h000000, 2'd0};
    vecs[1]  = '{OP_TICK, 37, 24'h000037, 2'd0};
    vecs[2]  = '{OP_MODE, 1,  24'h000037, 2'd1};
    vecs[3]  = '{OP_INC,  5,  24'h050037, 2'd1};
    vecs[4]  = '{OP_TICK, 3,  24'h050037, 2'd1};
    vecs[5]  = '{OP_MODE, 1,  24'h050037, 2'd2};
    vecs[6]  = '{OP_INC,  61, 24'h050137, 2'd2};
    vecs[7]  = '{OP_TICK, 2,  24'h050137, 2'd2};
    vecs[8]  = '{OP_MODE, 1,  24'h050100, 2'd0};
    vecs[9]  = '{OP_TICK, 1,  24'h050101, 2'd0};
    vecs[10] = '{OP_RST,  1,  24'h000000, 2'd0};
    vecs[11] = '{OP_INC,  3,  24'h000000, 2'd0};
    vecs[12] = '{OP_BOTH, 1,  24'h000000, 2'd1};
    vecs[13] = '{OP_INC,  23, 24'h230000, 2'd1};
    vecs[14] = '{OP_BOTH, 1,  24'h230000, 2'd2};
    vecs[15] = '{OP_INC,  59, 24'h235900, 2'd2};
    vecs[16] = '{OP_MODE, 1,  24'h235900, 2'd0};
    vecs[17] = '{OP_TICK, 58, 24'h235958, 2'd0};
    vecs[18] = '{OP_TICK, 1,  24'h235959, 2'd0};
    vecs[19] = '{OP_TICK, 1,  24'h000000, 2'd0};

    // Reset with tick toggling, single-cycle advance latency, then a full minute of strobes.
    @(negedge clk);
    reset_hold();
    check("rst_time24", 32'(a_time), 32'h000000);
    check("rst_mode", 32'(a_mode), 32'd0);
    check("rst_pulse", 32'(a_sp), 32'd0);
    check("rst_time12", 32'(b_time), 32'h120000);
    check("rst_pm12", 32'(b_pm), 32'd0);
    reset_release();
    p0 = a_pulses;
    tick = 1'b1;
    @(negedge clk);
    check("first_rise_time", 32'(a_time), 32'h000001);
    check("first_rise_pulse", 32'(a_sp), 32'd1);
    tick = 1'b0;
    @(negedge clk);
    check("pulse_one_cycle", 32'(a_sp), 32'd0);
    apply_op(OP_TICK, 59);
    check("minute_time", 32'(a_time), 32'h000100);
    check("minute_pulses", 32'(a_pulses - p0), 32'd60);

    for (int r = 0; r < 20; r++) begin
      apply_op(vecs[r].op, vecs[r].n);
      check($sformatf("row%0d_time", r), 32'(a_time), 32'(vecs[r].exp_time));
      check($sformatf("row%0d_mode", r), 32'(a_mode), 32'(vecs[r].exp_mode));
    end
    check("pm24_tied", 32'(a_pm), 32'd0);

    // 12h mode: 11->12 toggles pm, 12->01 keeps it.
    apply_op(OP_RST, 1);
    apply_op(OP_MODE, 1);
    apply_op(OP_INC, 11);
    check("h12_set11", 32'(b_time), 32'h110000);
    check("h12_set11_pm", 32'(b_pm), 32'd0);
    apply_op(OP_MODE, 1);
    apply_op(OP_INC, 59);
    apply_op(OP_MODE, 1);
    apply_op(OP_TICK, 59);
    check("h12_115959", 32'(b_time), 32'h115959);
    check("h12_115959_pm", 32'(b_pm), 32'd0);
    apply_op(OP_TICK, 1);
    check("h12_noon", 32'(b_time), 32'h120000);
    check("h12_noon_pm", 32'(b_pm), 32'd1);
    apply_op(OP_MODE, 2);
    apply_op(OP_INC, 59);
    apply_op(OP_MODE, 1);
    apply_op(OP_TICK, 59);
    check("h12_125959", 32'(b_time), 32'h125959);
    apply_op(OP_TICK, 1);
    check("h12_one", 32'(b_time), 32'h010000);
    check("h12_one_pm", 32'(b_pm), 32'd1);

    // Four rises per second; reset mid-count must drop the partial prescale.
    apply_op(OP_RST, 1);
    apply_op(OP_TICK, 7);
    check("tps4_7rises", 32'(c_time), 32'h000001);
    reset_hold();
    check("tps4_rst", 32'(c_time), 32'h000000);
    reset_release();
    apply_op(OP_TICK, 3);
    check("tps4_3rises", 32'(c_time), 32'h000000);
    apply_op(OP_TICK, 1);
    check("tps4_4rises", 32'(c_time), 32'h000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
